conv_enc_k7: RTL
================

CONV_ENC_K7 -- requirements
Module: conv_enc_k7

Interface
REQ-001 SHALL have parameter G0, default 7'o171, generator polynomial for code bit c0; bit 6 taps the current input.
REQ-002 SHALL have parameter G1, default 7'o133, generator polynomial for code bit c1; bit 6 taps the current input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_bit, input, 1, information bit.
REQ-006 SHALL have port in_valid, input, 1, in_bit/in_last are valid.
REQ-007 SHALL have port in_last, input, 1, marks the final information bit of a frame.
REQ-008 SHALL have port in_ready, output, 1, encoder accepts the input this cycle.
REQ-009 SHALL have port tx_pair, output, 2, encoded symbol pair: {c0,c1}, c0 on tx_pair[1].
REQ-010 SHALL have port tx_valid, output, 1, tx_pair is valid.
REQ-011 SHALL have port tx_last, output, 1, tx_pair is the final (tail) pair of a frame.
REQ-012 SHALL have port tx_ready, input, 1, downstream accepts tx_pair this cycle.
REQ-013 SHALL have port busy, output, 1, high in state TAIL or while tx_valid is high.

Function
REQ-014 SHALL encode rate 1/2, constraint length 7, 64-state, non-recursive and non-punctured.
REQ-015 SHALL hold a 6-bit history sr[5:0], sr[5] = most recent bit; window w[6:0] = {bit, sr[5:0]}.
REQ-016 SHALL compute c0 = XOR-reduce(w & G0) and c1 = XOR-reduce(w & G1).
REQ-017 SHALL shift on each encoded bit: sr <= {bit, sr[5:1]}.
REQ-018 SHALL have FSM states ENC and TAIL; reset state is ENC.
REQ-019 SHALL, in ENC, transfer an input when in_valid && in_ready.
REQ-020 SHALL, in ENC, drive in_ready = !tx_valid || tx_ready.
REQ-021 SHALL, in TAIL, drive in_ready = 0 and ignore in_valid.
REQ-022 SHALL register the output (one stage): an input accepted at edge N gives tx_valid=1 and its tx_pair after edge N.
REQ-023 SHALL hold tx_pair/tx_valid/tx_last stable while tx_valid && !tx_ready.
REQ-024 SHALL clear tx_valid on a transfer (tx_valid && tx_ready) when no new symbol is produced in the same cycle.
REQ-025 SHALL, when tx_ready=1, sustain one accepted bit and one output pair per cycle.
REQ-026 SHALL, on accepting in_last=1, enter TAIL with tail counter tcnt=0; that symbol has tx_last=0.
REQ-027 SHALL, in TAIL, encode bit=0 whenever the output register is free (!tx_valid || tx_ready) and increment tcnt (3-bit).
REQ-028 SHALL, in TAIL, emit exactly 6 tail pairs, set tx_last=1 on the 6th, and return to ENC after that pair is generated.
REQ-029 SHALL leave sr = 0 at frame end, so no clearing is needed between frames.
REQ-030 SHALL allow a new frame's first bit to be accepted the cycle after returning to ENC.
REQ-031 SHALL, on in_valid=1 with no accept (in_ready=0), change no state.
REQ-032 SHALL, for a frame of N information bits, output exactly N+6 pairs.

Reset
REQ-033 SHALL, while rst=1 and independent of clk, force sr=0, tcnt=0, state=ENC, tx_valid=0, tx_last=0, tx_pair=2'b00.
REQ-034 SHALL, under reset, drive in_ready=1 and busy=0 as combinational results of the reset state.
REQ-035 SHALL, on reset mid-frame or mid-TAIL, abandon the frame and restart cleanly after rst deasserts.

Verification
REQ-036 SHALL test reset: assert rst asynchronously mid-cycle -> tx_valid=0, tx_pair=00, in_ready=1 immediately.
REQ-037 SHALL test impulse: tx_ready=1, one bit in_bit=1 with in_last=1 -> pairs 11,10,11,11,00,01,11 on consecutive cycles, tx_last only on the 7th, in_ready=0 for 6 cycles.
REQ-038 SHALL test backpressure: tx_ready=0 for 3 cycles with tx_valid=1 -> tx_pair held, in_ready=0, sr unchanged; stream resumes with no loss or duplication.
REQ-039 SHALL test back-to-back frames: frame 1011 (last on 4th) then frame 1 -> 10 and 7 pairs; the second frame's first pair equals the impulse start 11.
REQ-040 SHALL test reset mid-TAIL: rst after the 3rd tail pair -> no further pairs; the next frame's all-zero input gives all-00 pairs.
REQ-041 SHALL test random frames of 1..200 bits with random tx_ready -> output matches a reference model; the bench's Viterbi decoder recovers the input exactly.

Source files
------------

// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 feed-forward convolutional encoder with a registered output
// stage and automatic 6-bit zero tail that flushes the trellis to state 0.
module conv_enc_k7 #(
  parameter logic [6:0] G0 = 7'o171,
  parameter logic [6:0] G1 = 7'o133
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] tx_pair,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic {ENC, TAIL} state_t;

  state_t     state;
  logic [5:0] sr;
  logic [2:0] tcnt;
  logic       slot_free;
  logic       accept;
  logic       gen;
  logic       enc_bit;
  logic [6:0] w;

  // The output register can take a new pair when empty or being drained now.
  assign slot_free = !tx_valid || tx_ready;
  assign in_ready  = (state == ENC) && slot_free;
  assign accept    = in_valid && in_ready;
  assign gen       = accept || ((state == TAIL) && slot_free);
  assign enc_bit   = (state == ENC) ? in_bit : 1'b0;
  assign w         = {enc_bit, sr};
  assign busy      = (state == TAIL) || tx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENC;
      sr       <= 6'd0;
      tcnt     <= 3'd0;
      tx_pair  <= 2'b00;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else if (gen) begin
      sr       <= {enc_bit, sr[5:1]};
      tx_pair  <= {^(w & G0), ^(w & G1)};
      tx_valid <= 1'b1;
      if (state == ENC) begin
        tx_last <= 1'b0;
        if (in_last) begin
          state <= TAIL;
          tcnt  <= 3'd0;
        end
      end else begin
        // Sixth tail bit closes the frame; sr is all-zero after it.
        tcnt    <= tcnt + 3'd1;
        tx_last <= (tcnt == 3'd5);
        if (tcnt == 3'd5) state <= ENC;
      end
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end
  end

endmodule
